// File: rtl/itch_pkg.sv
// Shared ITCH decoder definitions: message types,
// Replace Order field layout and decoder states.
package itch_pkg;

  localparam logic [7:0] ITCH_TYPE_ADD     = 8'h41;
  localparam logic [7:0] ITCH_TYPE_DELETE  = 8'h44;
  localparam logic [7:0] ITCH_TYPE_EXEC    = 8'h45;
  localparam logic [7:0] ITCH_TYPE_REPLACE = 8'h55;
  localparam logic [7:0] ITCH_TYPE_CANCEL  = 8'h58;

  localparam int REPLACE_LEN = 27;

  localparam int OLD_REF_OFF = 1;
  localparam int OLD_REF_LEN = 8;
  localparam int NEW_REF_OFF = 9;
  localparam int NEW_REF_LEN = 8;
  localparam int SHARES_OFF  = 17;
  localparam int SHARES_LEN  = 4;
  localparam int PRICE_OFF   = 21;
  localparam int PRICE_LEN   = 4;

  typedef enum logic [1:0] {
    IDLE,
    PARSE,
    SKIP
  } dec_state_e;

endpackage

// File: rtl/itch_lane_capture.sv
// One big-endian message field, loaded from whichever
// beat lanes land on its byte offsets.
module itch_lane_capture #(
  parameter int BPC         = 4,
  parameter int FIELD_OFF   = 1,
  parameter int FIELD_BYTES = 8,
  parameter int OFF_W       = 6,
  localparam int CW         = $clog2(BPC) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [OFF_W-1:0]         off,
  input  logic [8*BPC-1:0]         data_in,
  input  logic [CW-1:0]            bytes_in,
  output logic [8*FIELD_BYTES-1:0] field
);

  logic [8*FIELD_BYTES-1:0] field_d;

  always_comb begin
    field_d = field;
    for (int k = 0; k < BPC; k++) begin
      for (int j = 0; j < FIELD_BYTES; j++) begin
        if (k < int'(bytes_in) &&
            int'(off) + k == FIELD_OFF + j)
          field_d[8*(FIELD_BYTES-1-j) +: 8] =
            data_in[8*k +: 8];
      end
    end
  end

  // clear wins over a same-cycle load
  always_ff @(posedge clk) begin
    if (rst || clr)
      field <= '0;
    else if (en)
      field <= field_d;
  end

endmodule

// File: rtl/itch_replace_decoder_wide.sv
// Multi-byte-per-beat Replace Order ('U') decoder with
// speculative first-beat capture and length qualification.
module itch_replace_decoder_wide
  import itch_pkg::*;
#(
  parameter int          BPC        = 4,
  parameter logic [7:0]  MSG_TYPE   = ITCH_TYPE_REPLACE,
  parameter int          MSG_LENGTH = REPLACE_LEN,
  parameter int          OFF_W      = 6,
  localparam int         CW         = $clog2(BPC) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BPC-1:0]   data_in,
  input  logic               valid_in,
  input  logic [CW-1:0]      bytes_in,
  input  logic               last_in,
  output logic               replace_internal_valid,
  output logic               replace_packet_invalid,
  output logic [63:0]        replace_old_order_ref,
  output logic [63:0]        replace_new_order_ref,
  output logic [31:0]        replace_shares,
  output logic [31:0]        replace_price
);

  localparam int SW = OFF_W + 1;

  dec_state_e       state, state_d;
  logic [OFF_W-1:0] off, off_d;
  logic [SW-1:0]    sum;
  logic             hit, len_eq, len_gt;
  logic             cap_en, clr, ok_d, bad_d;

  assign sum    = {1'b0, off} + SW'(bytes_in);
  assign len_eq = (sum == SW'(MSG_LENGTH));
  assign len_gt = (sum >  SW'(MSG_LENGTH));
  assign hit    = (state == PARSE) ||
                  (data_in[7:0] == MSG_TYPE);

  always_comb begin
    state_d = state;
    off_d   = off;
    cap_en  = 1'b0;
    clr     = 1'b0;
    ok_d    = 1'b0;
    bad_d   = 1'b0;
    if (valid_in) begin
      unique case (state)
        SKIP: begin
          off_d = sum[OFF_W] ? '1 : sum[OFF_W-1:0];
          if (last_in) begin
            state_d = IDLE;
            off_d   = '0;
          end
        end
        default: begin
          cap_en = 1'b1;
          off_d  = sum[OFF_W-1:0];
          if (last_in) begin
            state_d = IDLE;
            off_d   = '0;
            ok_d    = hit && len_eq;
            bad_d   = hit && !len_eq;
          end else if (!hit) begin
            state_d = SKIP;
          end else if (len_gt) begin
            state_d = SKIP;
            bad_d   = 1'b1;
          end else begin
            state_d = PARSE;
          end
          clr = bad_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      off                    <= '0;
      replace_internal_valid <= 1'b0;
      replace_packet_invalid <= 1'b0;
    end else begin
      state                  <= state_d;
      off                    <= off_d;
      replace_internal_valid <= ok_d;
      replace_packet_invalid <= bad_d;
    end
  end

  itch_lane_capture #(
    .BPC(BPC), .FIELD_OFF(OLD_REF_OFF),
    .FIELD_BYTES(OLD_REF_LEN), .OFF_W(OFF_W)
  ) u_old_ref (
    .clk(clk), .rst(rst), .en(cap_en), .clr(clr),
    .off(off), .data_in(data_in), .bytes_in(bytes_in),
    .field(replace_old_order_ref)
  );

  itch_lane_capture #(
    .BPC(BPC), .FIELD_OFF(NEW_REF_OFF),
    .FIELD_BYTES(NEW_REF_LEN), .OFF_W(OFF_W)
  ) u_new_ref (
    .clk(clk), .rst(rst), .en(cap_en), .clr(clr),
    .off(off), .data_in(data_in), .bytes_in(bytes_in),
    .field(replace_new_order_ref)
  );

  itch_lane_capture #(
    .BPC(BPC), .FIELD_OFF(SHARES_OFF),
    .FIELD_BYTES(SHARES_LEN), .OFF_W(OFF_W)
  ) u_shares (
    .clk(clk), .rst(rst), .en(cap_en), .clr(clr),
    .off(off), .data_in(data_in), .bytes_in(bytes_in),
    .field(replace_shares)
  );

  itch_lane_capture #(
    .BPC(BPC), .FIELD_OFF(PRICE_OFF),
    .FIELD_BYTES(PRICE_LEN), .OFF_W(OFF_W)
  ) u_price (
    .clk(clk), .rst(rst), .en(cap_en), .clr(clr),
    .off(off), .data_in(data_in), .bytes_in(bytes_in),
    .field(replace_price)
  );

endmodule

// File: tb/tb_itch_replace_decoder_wide.sv
// Bench for the wide Replace decoder at BPC = 4, 1 and 8,
// checked against a whole-message outcome model.
module tb_itch_replace_decoder_wide;

  typedef logic [7:0] bq_t[$];

  localparam logic [191:0] LIT = {64'h0102030405060708,
                                  64'h1112131415161718,
                                  32'd100, 32'h0000_2710};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass   = 0;
  int   n_tot    = 0;
  logic fin      = 1'b0;
  logic fin_seen = 1'b0;

  function automatic bq_t mk_u(input int len,
                               input logic [191:0] f);
    bq_t        m;
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i == 0)       b = 8'h55;
      else if (i <= 24) b = f[8*(24-i) +: 8];
      else              b = 8'($urandom);
      m.push_back(b);
    end
    return m;
  endfunction

  function automatic bq_t mk_raw(input logic [7:0] t,
                                 input int len);
    bq_t m;
    m.push_back(t);
    for (int i = 1; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  function automatic logic [191:0] rnd_f();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int b,
                     input logic [191:0] got,
                     input logic [191:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s bpc=%0d t=%0t got=%h want=%h",
                  name, b, $time, got, want);
  endtask

  task automatic chk_one(input int b, input int ev,
                         input logic [191:0] ef,
                         input logic pin, input logic er,
                         input logic iv, input logic pi,
                         input logic [191:0] got);
    chk("valid_pulse", b, 192'(iv), 192'(ev == 1));
    chk("invalid_pulse", b, 192'(pi), 192'(ev == 2));
    if (ev == 1) chk("fields", b, got, ef);
    if (ev == 2) chk("fields_zeroed", b, got, '0);
    if (ev == 1 && pin) chk("fields_literal", b, got, LIT);
    if (er) chk("reset_fields", b, got, '0);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int B  = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    localparam int CW = $clog2(B) + 1;

    logic           rst      = 1'b1;
    logic [8*B-1:0] data_in  = '0;
    logic           valid_in = 1'b0;
    logic [CW-1:0]  bytes_in = CW'(B);
    logic           last_in  = 1'b0;
    logic           iv, pi;
    logic [63:0]    old_ref, new_ref;
    logic [31:0]    shares, price;
    int             exp_ev   = 0;
    logic [191:0]   exp_f    = '0;
    logic           exp_pin  = 1'b0;
    logic           exp_rst  = 1'b0;
    logic           pin_cur  = 1'b0;
    logic           chk_on   = 1'b0;
    logic           done     = 1'b0;

    itch_replace_decoder_wide #(.BPC(B)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .data_in                (data_in),
      .valid_in               (valid_in),
      .bytes_in               (bytes_in),
      .last_in                (last_in),
      .replace_internal_valid (iv),
      .replace_packet_invalid (pi),
      .replace_old_order_ref  (old_ref),
      .replace_new_order_ref  (new_ref),
      .replace_shares         (shares),
      .replace_price          (price)
    );

    // drive one cycle; afterwards publish what that edge must produce
    task automatic beat(input logic v, input logic [8*B-1:0] d,
                        input int n, input logic l, input int ev,
                        input logic [191:0] f, input logic r);
      rst = r; valid_in = v; data_in = d;
      bytes_in = CW'(n); last_in = l;
      @(posedge clk);
      #1;
      exp_ev = ev; exp_f = f; exp_pin = pin_cur; exp_rst = r;
    endtask

    task automatic idle(input int c);
      for (int i = 0; i < c; i++)
        beat(1'b0, '0, B, 1'b0, 0, '0, 1'b0);
    endtask

    // outcome decided from the whole message: type, length, fields
    task automatic send(input bq_t m, input int gap_pct,
                        input int gap_at, input int abort_at);
      int             len, nb, ev_beat, ev_kind, n;
      logic [191:0]   f;
      logic [63:0]    r;
      logic [8*B-1:0] d;
      len = m.size(); nb = (len + B - 1) / B;
      ev_beat = -1; ev_kind = 0; f = '0;
      if (m[0] == 8'h55) begin
        ev_kind = (len == 27) ? 1 : 2;
        ev_beat = nb - 1;
        if (len == 27)
          for (int i = 1; i <= 24; i++) f[8*(24-i) +: 8] = m[i];
        if (len > 27)
          for (int i = nb - 1; i >= 0; i--)
            if ((i + 1) * B > 27) ev_beat = i;
      end
      for (int i = 0; i < nb; i++) begin
        if (i == abort_at) begin
          beat(1'b0, '0, B, 1'b0, 0, '0, 1'b1);
          return;
        end
        if (i == gap_at) idle(3);
        while (int'($urandom_range(99)) < gap_pct) idle(1);
        n = (i == nb - 1) ? len - i * B : B;
        r = {$urandom, $urandom};
        d = r[8*B-1:0];
        for (int k = 0; k < n; k++) d[8*k +: 8] = m[i*B + k];
        beat(1'b1, d, n, i == nb - 1,
             (i == ev_beat) ? ev_kind : 0, f, 1'b0);
      end
    endtask

    initial begin
      int ulen[10];
      int sel;
      ulen = '{27, 27, 27, 20, 1, 26, 28, 29, 32, 40};
      beat(1'b0, '0, B, 1'b0, 0, '0, 1'b1);
      chk_on = 1'b1;
      beat(1'b0, '0, B, 1'b0, 0, '0, 1'b1);
      idle(2);
      pin_cur = 1'b1;
      send(mk_u(27, LIT), 0, -1, -1);
      send(mk_u(27, LIT), 0, 2, -1);
      pin_cur = 1'b0;
      send(mk_raw(8'h41, 36), 0, -1, -1);
      send(mk_u(27, rnd_f()), 0, -1, -1);
      send(mk_u(20, rnd_f()), 0, -1, -1);
      send(mk_u(32, rnd_f()), 0, -1, -1);
      send(mk_u(27, rnd_f()), 0, -1, -1);
      send(mk_u(27, rnd_f()), 0, -1, 2);
      send(mk_u(27, rnd_f()), 0, -1, -1);
      send(mk_raw(8'h41, 100), 0, -1, -1);
      send(mk_u(28, rnd_f()), 0, -1, -1);
      send(mk_u(1, rnd_f()), 0, -1, -1);
      send(mk_u(27, rnd_f()), 0, -1, -1);
      for (int t = 0; t < 120; t++) begin
        sel = int'($urandom_range(9));
        if (sel < 2)
          send(mk_raw(8'($urandom), int'($urandom_range(1, 60))),
               20, -1, -1);
        else
          send(mk_u(ulen[$urandom_range(9)], rnd_f()),
               (sel < 5) ? 0 : 25, -1, -1);
      end
      idle(3);
      done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (g_inst[0].chk_on)
      chk_one(4, g_inst[0].exp_ev, g_inst[0].exp_f,
              g_inst[0].exp_pin, g_inst[0].exp_rst,
              g_inst[0].iv, g_inst[0].pi,
              {g_inst[0].old_ref, g_inst[0].new_ref,
               g_inst[0].shares, g_inst[0].price});
    if (g_inst[1].chk_on)
      chk_one(1, g_inst[1].exp_ev, g_inst[1].exp_f,
              g_inst[1].exp_pin, g_inst[1].exp_rst,
              g_inst[1].iv, g_inst[1].pi,
              {g_inst[1].old_ref, g_inst[1].new_ref,
               g_inst[1].shares, g_inst[1].price});
    if (g_inst[2].chk_on)
      chk_one(8, g_inst[2].exp_ev, g_inst[2].exp_f,
              g_inst[2].exp_pin, g_inst[2].exp_rst,
              g_inst[2].iv, g_inst[2].pi,
              {g_inst[2].old_ref, g_inst[2].new_ref,
               g_inst[2].shares, g_inst[2].price});
    if (fin && !fin_seen) begin
      chk("all_done", 0,
          192'(g_inst[0].done & g_inst[1].done & g_inst[2].done),
          192'(1));
      fin_seen = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 40000; c++) begin
      if (g_inst[0].done && g_inst[1].done && g_inst[2].done)
        break;
      @(posedge clk);
    end
    fin = 1'b1;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
